// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling LED-matrix frame: FSM states,
// shift-direction encodings and matrix geometry.
package scroll_pkg;

  localparam int COLS_PER_MATRIX = 8;

  // Direction encodings for the dir input and the row shifters.
  localparam logic DIR_UP   = 1'b0;  // shift toward column MSB
  localparam logic DIR_DOWN = 1'b1;  // shift toward column LSB

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/scroll_frame_row_shift.sv
// One pixel row of the frame: a W-bit shift register that shifts one column
// per enabled cycle and exposes the bit that the next shift would eject.
module row_shift
  import scroll_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         dir,
  input  logic         in,
  output logic [W-1:0] out,
  output logic         ej
);

  logic [W-1:0] row_q;
  logic [W-1:0] row_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    row_d = row_q;
    if (clr) begin
      row_d = '0;
    end else if (en) begin
      row_d = (dir == DIR_UP) ? {row_q[W-2:0], in} : {in, row_q[W-1:1]};
    end
  end

  // NOTE: flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) row_q <= '0;
    else     row_q <= row_d;
  end

  assign out = row_q;
  // Combinational: feeds both the rotate path and the ex capture register.
  assign ej  = (dir == DIR_UP) ? row_q[W-1] : row_q[0];

endmodule

// File: rtl/scroll_frame.sv
// Scrolling frame controller: runs a counted sequence of column shifts across
// ROWS row registers, either rotating or streaming in new column data.
module scroll_frame
  import scroll_pkg::*;
#(
  parameter  int N_MATRIX = 4,
  parameter  int ROWS     = 8,
  localparam int W        = COLS_PER_MATRIX * N_MATRIX,
  parameter  int CW       = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     steps,
  input  logic              dir,
  input  logic              wrap,
  input  logic              tick,
  input  logic              col_valid,
  output logic              col_ready,
  input  logic [ROWS-1:0]   col_data,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic [ROWS-1:0]   ex,
  output logic [ROWS*W-1:0] frame
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            wrap_q, wrap_d;
  logic [ROWS-1:0] ex_q, ex_d;

  logic            shift_en;
  logic [ROWS-1:0] row_in;
  logic [ROWS-1:0] row_ej;

  // A rotate needs no external data; a streamed shift waits for a valid column.
  assign shift_en = (state_q == ST_SHIFT) && tick && (wrap_q || col_valid) && !clr;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_in[r] = wrap_q ? row_ej[r] : col_data[r];

    row_shift #(.W(W)) u_row (
      .clk (clk),
      .rst (rst),
      .en  (shift_en),
      .clr (clr),
      .dir (dir_q),
      .in  (row_in[r]),
      .out (frame[r*W +: W]),
      .ej  (row_ej[r])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    ex_d    = ex_q;

    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ex_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (steps != '0) begin
              state_d = ST_SHIFT;
              cnt_d   = steps;
              dir_d   = dir;
              wrap_d  = wrap;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_en) begin
            ex_d  = row_ej;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      ex_q    <= ex_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign col_ready = (state_q == ST_SHIFT) && !wrap_q && tick;
  assign ex        = ex_q;

endmodule

// File: tb/tb_scroll_frame.sv
// Self-checking bench for scroll_frame (one 8x8 matrix) against a
// cycle-level behavioural model built from row arithmetic.
module tb_scroll_frame;

  localparam int N_MATRIX = 1;
  localparam int ROWS     = 8;
  localparam int W        = 8;
  localparam int CW       = $clog2(W + 1);

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_FIN  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CW-1:0]     steps;
  logic              dir;
  logic              wrap;
  logic              tick;
  logic              col_valid;
  logic              col_ready;
  logic [ROWS-1:0]   col_data;
  logic              clr;
  logic              busy;
  logic              done;
  logic [ROWS-1:0]   ex;
  logic [ROWS*W-1:0] frame;

  scroll_frame #(.N_MATRIX(N_MATRIX), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .steps     (steps),
    .dir       (dir),
    .wrap      (wrap),
    .tick      (tick),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .clr       (clr),
    .busy      (busy),
    .done      (done),
    .ex        (ex),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [W-1:0]    m_rows [ROWS];
  logic [ROWS-1:0] m_ex;
  int              m_phase;
  int              m_rem;
  logic            m_dir;
  logic            m_wrap;

  int n_vec;
  int n_err;
  int done_seen;
  int hs_count;
  int ready_bad;

  function automatic logic [ROWS*W-1:0] m_frame();
    logic [ROWS*W-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[r*W +: W] = m_rows[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    m_ex    = '0;
    m_phase = P_IDLE;
    m_rem   = 0;
    m_dir   = 1'b0;
    m_wrap  = 1'b0;
  endtask

  task automatic model_edge();
    logic ejb;
    logic inb;
    if (clr) begin
      for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
      m_ex    = '0;
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (start) begin
            if (steps != 0) begin
              m_phase = P_RUN;
              m_rem   = int'(steps);
              m_dir   = dir;
              m_wrap  = wrap;
            end else begin
              m_phase = P_FIN;
            end
          end
        end
        P_RUN: begin
          if (tick && (m_wrap || col_valid)) begin
            for (int r = 0; r < ROWS; r++) begin
              if (!m_dir) begin
                ejb = m_rows[r][W-1];
                inb = m_wrap ? ejb : col_data[r];
                m_rows[r] = W'((m_rows[r] * 2) + inb);
              end else begin
                ejb = m_rows[r][0];
                inb = m_wrap ? ejb : col_data[r];
                m_rows[r] = (m_rows[r] >> 1) | (W'(inb) << (W - 1));
              end
              m_ex[r] = ejb;
            end
            m_rem = m_rem - 1;
            if (m_rem == 0) m_phase = P_FIN;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic set_idle_inputs();
    start     = 1'b0;
    steps     = '0;
    dir       = 1'b0;
    wrap      = 1'b0;
    tick      = 1'b0;
    col_valid = 1'b0;
    col_data  = '0;
    clr       = 1'b0;
  endtask

  // One clock: checks combinational outputs against the model with the
  // current inputs, advances the model, then checks the registered state.
  task automatic drive_cycle();
    logic exp_busy, exp_done, exp_ready;
    #1;
    exp_busy  = (m_phase == P_RUN);
    exp_done  = (m_phase == P_FIN);
    exp_ready = (m_phase == P_RUN) && !m_wrap && tick;
    n_vec++;
    if (busy !== exp_busy) begin
      n_err++; $display("FAIL busy_pre: got %b want %b", busy, exp_busy);
    end
    n_vec++;
    if (done !== exp_done) begin
      n_err++; $display("FAIL done_pre: got %b want %b", done, exp_done);
    end
    n_vec++;
    if (col_ready !== exp_ready) begin
      n_err++; $display("FAIL col_ready: got %b want %b", col_ready, exp_ready);
    end
    if (col_ready === 1'b1 && col_valid) hs_count++;
    if (col_ready === 1'b1 && !tick) ready_bad++;
    model_edge();
    @(posedge clk);
    #1;
    exp_busy = (m_phase == P_RUN);
    exp_done = (m_phase == P_FIN);
    n_vec++;
    if (busy !== exp_busy) begin
      n_err++; $display("FAIL busy_post: got %b want %b", busy, exp_busy);
    end
    n_vec++;
    if (done !== exp_done) begin
      n_err++; $display("FAIL done_post: got %b want %b", done, exp_done);
    end
    n_vec++;
    if (frame !== m_frame()) begin
      n_err++; $display("FAIL frame: got %h want %h", frame, m_frame());
    end
    n_vec++;
    if (ex !== m_ex) begin
      n_err++; $display("FAIL ex: got %h want %h", ex, m_ex);
    end
    if (done === 1'b1) done_seen++;
  endtask

  task automatic idle_cycles(input int n);
    set_idle_inputs();
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic test_reset();
    set_idle_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    n_vec++;
    if ({busy, done, col_ready} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, col_ready});
    end
    n_vec++;
    if (frame !== '0 || ex !== '0) begin
      n_err++; $display("FAIL reset_data: frame %h ex %h want 0", frame, ex);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_fill();
    logic prev_busy;
    set_idle_inputs();
    done_seen = 0;
    start = 1'b1; steps = CW'(3); tick = 1'b1; col_valid = 1'b1; col_data = 8'hFF;
    drive_cycle();
    start = 1'b0;
    prev_busy = busy;
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      if (done === 1'b1) begin
        n_vec++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
          n_err++; $display("FAIL fill_busy_fall: busy %b prev %b want 0/1", busy, prev_busy);
        end
      end
      prev_busy = busy;
    end
    for (int r = 0; r < ROWS; r++) begin
      n_vec++;
      if (frame[r*W +: W] !== 8'b00000111) begin
        n_err++; $display("FAIL fill_row%0d: got %b want 00000111", r, frame[r*W +: W]);
      end
    end
    n_vec++;
    if (done_seen !== 1) begin
      n_err++; $display("FAIL fill_done_count: got %0d want 1", done_seen);
    end
    idle_cycles(1);
  endtask

  task automatic test_rotate();
    logic [W-1:0] pre_row;
    pre_row = 8'b10000001;
    set_idle_inputs();
    clr = 1'b1;
    drive_cycle();
    clr = 1'b0;
    start = 1'b1; steps = CW'(8); tick = 1'b1; col_valid = 1'b1;
    drive_cycle();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      col_data = ROWS'($urandom);
      col_data[0] = pre_row[W-1-k];
      drive_cycle();
    end
    idle_cycles(2);
    n_vec++;
    if (frame[0 +: W] !== pre_row) begin
      n_err++; $display("FAIL preload_row0: got %b want %b", frame[0 +: W], pre_row);
    end
    start = 1'b1; steps = CW'(8); dir = 1'b1; wrap = 1'b1; tick = 1'b1;
    drive_cycle();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      col_valid = 1'($urandom);
      col_data  = ROWS'($urandom);
      drive_cycle();
      n_vec++;
      if (ex[0] !== pre_row[k]) begin
        n_err++; $display("FAIL rotate_ex0_%0d: got %b want %b", k, ex[0], pre_row[k]);
      end
    end
    n_vec++;
    if (frame[0 +: W] !== pre_row) begin
      n_err++; $display("FAIL rotate_row0: got %b want %b", frame[0 +: W], pre_row);
    end
    idle_cycles(2);
  endtask

  task automatic test_throttle();
    int ticked;
    set_idle_inputs();
    done_seen = 0; hs_count = 0; ready_bad = 0; ticked = 0;
    start = 1'b1; steps = CW'(4); dir = 1'($urandom);
    drive_cycle();
    start = 1'b0;
    for (int i = 0; i < 30 && done_seen == 0; i++) begin
      tick      = (i % 2 == 0);
      col_valid = (ticked >= 2);
      col_data  = ROWS'($urandom);
      if (tick && m_phase == P_RUN) ticked++;
      drive_cycle();
    end
    n_vec++;
    if (hs_count !== 4) begin
      n_err++; $display("FAIL throttle_shifts: got %0d want 4", hs_count);
    end
    n_vec++;
    if (ready_bad !== 0) begin
      n_err++; $display("FAIL throttle_ready_untick: got %0d want 0", ready_bad);
    end
    n_vec++;
    if (done_seen !== 1) begin
      n_err++; $display("FAIL throttle_done: got %0d want 1", done_seen);
    end
    idle_cycles(2);
  endtask

  task automatic test_zero_steps();
    logic [ROWS*W-1:0] snap;
    int done_at;
    int busy_rise;
    snap = m_frame();
    set_idle_inputs();
    done_seen = 0; done_at = 0; busy_rise = 0;
    start = 1'b1; steps = '0; dir = 1'b1; wrap = 1'b1; tick = 1'b1; col_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_cycle();
      if (i == 1) start = 1'b0;
      if (done === 1'b1 && done_at == 0) done_at = i + 1;
      if (busy === 1'b1) busy_rise++;
    end
    n_vec++;
    if (done_at !== 2 || done_seen !== 1) begin
      n_err++; $display("FAIL zero_done: at cycle %0d count %0d want 2/1", done_at, done_seen);
    end
    n_vec++;
    if (busy_rise !== 0) begin
      n_err++; $display("FAIL zero_busy: got %0d want 0", busy_rise);
    end
    n_vec++;
    if (frame !== snap) begin
      n_err++; $display("FAIL zero_frame: got %h want %h", frame, snap);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    set_idle_inputs();
    done_seen = 0;
    start = 1'b1; steps = CW'(6); dir = 1'($urandom); tick = 1'b1; col_valid = 1'b1;
    drive_cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      col_data = ROWS'($urandom) | 8'h01;
      drive_cycle();
    end
    if (use_rst) begin
      #2 rst = 1'b1;
      #2 model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      clr = 1'b1; start = 1'b1;
      drive_cycle();
      clr = 1'b0; start = 1'b0;
    end
    n_vec++;
    if (frame !== '0 || ex !== '0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_state(rst=%0d): frame %h ex %h busy %b want 0", use_rst, frame, ex, busy);
    end
    idle_cycles(8);
    n_vec++;
    if (done_seen !== 0) begin
      n_err++; $display("FAIL abort_no_done(rst=%0d): got %0d want 0", use_rst, done_seen);
    end
    start = 1'b1; steps = CW'(1); tick = 1'b1; col_valid = 1'b1; col_data = ROWS'($urandom);
    drive_cycle();
    start = 1'b0;
    for (int i = 0; i < 6 && done_seen == 0; i++) drive_cycle();
    n_vec++;
    if (done_seen !== 1) begin
      n_err++; $display("FAIL abort_restart(rst=%0d): done count %0d want 1", use_rst, done_seen);
    end
    idle_cycles(1);
  endtask

  task automatic test_start_busy();
    set_idle_inputs();
    done_seen = 0; hs_count = 0;
    start = 1'b1; steps = CW'(5); tick = 1'b1; col_valid = 1'b1;
    drive_cycle();
    for (int i = 0; i < 12 && done_seen == 0; i++) begin
      start    = (i >= 1 && i <= 3);
      steps    = CW'(2);
      col_data = ROWS'($urandom);
      drive_cycle();
    end
    start = 1'b1;
    drive_cycle();
    start = 1'b0;
    n_vec++;
    if (hs_count !== 5) begin
      n_err++; $display("FAIL busy_start_shifts: got %0d want 5", hs_count);
    end
    n_vec++;
    if (done_seen !== 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL busy_start_done: count %0d busy %b want 1/0", done_seen, busy);
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      set_idle_inputs();
      start = 1'b1;
      steps = CW'($urandom_range(0, 15));
      dir   = 1'($urandom);
      wrap  = 1'($urandom);
      for (int i = 0; i < 40; i++) begin
        tick      = ($urandom_range(0, 9) < 7);
        col_valid = 1'($urandom);
        col_data  = ROWS'($urandom);
        clr       = ($urandom_range(0, 29) == 0);
        drive_cycle();
        start = ($urandom_range(0, 9) == 0);
        steps = CW'($urandom_range(0, 15));
      end
    end
    idle_cycles(2);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    done_seen = 0; hs_count = 0; ready_bad = 0;
    model_reset();
    test_reset();
    test_fill();
    test_rotate();
    test_throttle();
    test_zero_steps();
    test_abort(1'b0);
    test_abort(1'b1);
    test_start_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
